// File: rtl/square_accum.sv
// Accumulates a run of 1..16 unsigned squares from an upstream squarer and
// presents the final sum until a consumer takes it.
module square_accum #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      sq_in,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  output logic [4:0]       count,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  // Handshake: a sample transfers on a rising edge where in_valid & in_ready;
  // the result transfers on a rising edge where sum_valid & out_ready.
  // Both ready/valid outputs are pure decodes of the registered state.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] sum_r, sum_nxt;
  logic [4:0]       count_r, count_nxt;
  logic [4:0]       target_r, target_nxt;
  logic [4:0]       count_inc;
  logic             accept;

  assign in_ready  = (state == ACCUM);
  assign sum_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum_out   = sum_r;
  assign count     = count_r;
  assign fsm_state = state;

  assign accept    = in_valid && in_ready;
  assign count_inc = count_r + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sum_r    <= '0;
      count_r  <= '0;
      target_r <= 5'd16;
    end else begin
      state    <= state_nxt;
      sum_r    <= sum_nxt;
      count_r  <= count_nxt;
      target_r <= target_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sum_nxt    = sum_r;
    count_nxt  = count_r;
    target_nxt = target_r;
    if (clear) begin
      state_nxt = IDLE;
      sum_nxt   = '0;
      count_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // A length field of zero encodes a full run of sixteen.
            target_nxt = (len == 4'd0) ? 5'd16 : {1'b0, len};
            sum_nxt    = '0;
            count_nxt  = '0;
            state_nxt  = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_nxt   = sum_r + ACC_W'(sq_in);
            count_nxt = count_inc;
            if (count_inc == target_r) state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_accum.sv
// Randomized and directed bench for square_accum against a sample-list
// reference model.
module tb_square_accum;

  localparam int ACC_W = 20;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       len;
  logic             clear;
  logic             in_valid;
  logic [15:0]      sq_in;
  logic             in_ready;
  logic             out_ready;
  logic [ACC_W-1:0] sum_out;
  logic             sum_valid;
  logic [4:0]       count;
  logic             busy;
  logic [1:0]       fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the list of samples taken in the current/last run,
  // the run length, and which phase the run is in.
  int          m_phase;   // 0 idle, 1 collecting, 2 result held
  int          m_target;
  int unsigned m_q[$];

  square_accum #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .clear     (clear),
    .in_valid  (in_valid),
    .sq_in     (sq_in),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .count     (count),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_sum();
    int unsigned s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_target = 16;
    m_q.delete();
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (clear) begin
      m_phase = 0;
      m_q.delete();
    end else if (m_phase == 0) begin
      if (start) begin
        m_q.delete();
        m_target = (len == 0) ? 16 : int'(len);
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_q.push_back(int'(sq_in));
        if (m_q.size() == m_target) m_phase = 2;
      end
    end else begin
      if (out_ready) m_phase = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_sum"},   32'(sum_out),   32'(m_sum()));
    check({tag, "_count"}, 32'(count),     32'(m_q.size()));
    check({tag, "_valid"}, 32'(sum_valid), 32'(m_phase == 2));
    check({tag, "_ready"}, 32'(in_ready),  32'(m_phase == 1));
    check({tag, "_busy"},  32'(busy),      32'(m_phase != 0));
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic [3:0] l, input logic c,
                       input logic v, input logic [15:0] d, input logic o);
    start = s; len = l; clear = c; in_valid = v; sq_in = d; out_ready = o;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic push(input logic [15:0] d, input string tag);
    drive(1'b0, 4'd0, 1'b0, 1'b1, d, 1'b0);
    step(tag);
  endtask

  task automatic begin_run(input logic [3:0] l, input string tag);
    drive(1'b1, l, 1'b0, 1'b0, 16'd0, 1'b0);
    step(tag);
  endtask

  task automatic take_result(input string tag);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    step(tag);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset");
    // in_valid high on the first live edge must not be taken
    drive(1'b0, 4'd0, 1'b0, 1'b1, 16'd77, 1'b0);
    step("idle_valid");

    // 25 + 144 + 100
    begin_run(4'd3, "r29_start");
    push(16'd25,  "r29_a");
    push(16'd144, "r29_b");
    check("r29_not_done", 32'(sum_valid), 32'd0);
    push(16'd100, "r29_c");
    check("r29_sum_lit", 32'(sum_out), 32'd269);
    check("r29_cnt_lit", 32'(count), 32'd3);
    check("r29_valid_lit", 32'(sum_valid), 32'd1);
    take_result("r29_take");
    idle_inputs();
    step("r29_idle_hold");
    check("r29_idle_sum_held", 32'(sum_out), 32'd269);

    // full-length run of maximal squares
    begin_run(4'd0, "r30_start");
    for (int i = 0; i < 16; i++) push(16'd65025, "r30_push");
    check("r30_sum_lit", 32'(sum_out), 32'd1040400);
    check("r30_cnt_lit", 32'(count), 32'd16);
    take_result("r30_take");

    // gap between samples
    begin_run(4'd2, "r31_start");
    push(16'd9, "r31_a");
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      step("r31_gap");
      check("r31_gap_cnt", 32'(count), 32'd1);
    end
    push(16'd49, "r31_b");
    check("r31_sum_lit", 32'(sum_out), 32'd58);

    // hold in DONE while start / in_valid pulse
    for (int i = 0; i < 5; i++) begin
      drive(1'(i % 2), 4'd5, 1'b0, 1'(~i[0]), 16'd1000, 1'b0);
      step("r32_hold");
      check("r32_hold_sum", 32'(sum_out), 32'd58);
    end
    take_result("r32_take");
    check("r32_idle_busy", 32'(busy), 32'd0);

    // asynchronous reset mid-run, away from any edge
    begin_run(4'd5, "r33_start");
    push(16'd4, "r33_a");
    push(16'd16, "r33_b");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("r33_async");
    idle_inputs();
    step("r33_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 16'd9, 1'b0);
    step("r33_release");
    // clear mid-run in another run, clear beating a simultaneous accept
    begin_run(4'd4, "r33c_start");
    push(16'd121, "r33c_a");
    drive(1'b1, 4'd0, 1'b1, 1'b1, 16'd36, 1'b1);
    step("r33c_clear");
    check("r33c_sum_lit", 32'(sum_out), 32'd0);

    // start and out_ready together in DONE only returns to IDLE
    begin_run(4'd1, "r34_start");
    push(16'd64, "r34_a");
    drive(1'b1, 4'd2, 1'b0, 1'b0, 16'd0, 1'b1);
    step("r34_both");
    check("r34_busy_lit", 32'(busy), 32'd0);
    idle_inputs();
    step("r34_stay_idle");

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int unsigned x;
      x = $urandom_range(0, 255);
      drive(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 9) < 6),
            16'(x * x), 1'($urandom_range(0, 3) == 0));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
